// File: rtl/arm_decode_stage.sv
// Decode stage: splits a fetched ARMv4 word into operand/control fields and evaluates the condition.
// The result is held in one registered record that execute takes with a valid/ready handshake.
module arm_decode_stage #(
  parameter int PC_W = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  input  logic [3:0]      flags_nzcv,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2:0]      out_class,
  output logic            out_cond_pass,
  output logic [3:0]      out_alu_op,
  output logic            out_set_flags,
  output logic [3:0]      out_rn,
  output logic [3:0]      out_rd,
  output logic [3:0]      out_rs,
  output logic [3:0]      out_rm,
  output logic            out_imm_en,
  output logic [31:0]     out_imm_val,
  output logic [4:0]      out_ls_ctl,
  output logic            out_br_link,
  output logic [PC_W-1:0] out_br_target,
  output logic [PC_W-1:0] out_pc
);

  localparam logic [2:0] CLS_DP     = 3'd0;
  localparam logic [2:0] CLS_MUL    = 3'd1;
  localparam logic [2:0] CLS_LDST   = 3'd2;
  localparam logic [2:0] CLS_BRANCH = 3'd3;
  localparam logic [2:0] CLS_UNDEF  = 3'd7;

  typedef struct packed {
    logic [2:0]      cls;
    logic            cond_pass;
    logic [3:0]      alu_op;
    logic            set_flags;
    logic [3:0]      rn;
    logic [3:0]      rd;
    logic [3:0]      rs;
    logic [3:0]      rm;
    logic            imm_en;
    logic [31:0]     imm_val;
    logic [4:0]      ls_ctl;
    logic            br_link;
    logic [PC_W-1:0] br_target;
    logic [PC_W-1:0] pc;
  } rec_t;

  rec_t       rec_q, rec_d, dec;
  logic       valid_q, valid_d;
  logic [3:0] cond;
  logic       flg_n, flg_z, flg_c, flg_v;
  logic       pass;
  logic [2:0] cls;
  logic [31:0] imm8_ext;
  logic [4:0]  rot_amt;
  logic [31:0] imm_rot;

  assign cond  = in_instr[31:28];
  assign flg_n = flags_nzcv[3];
  assign flg_z = flags_nzcv[2];
  assign flg_c = flags_nzcv[1];
  assign flg_v = flags_nzcv[0];

  always_comb begin
    pass = 1'b0;
    case (cond)
      4'h0: pass = flg_z;
      4'h1: pass = !flg_z;
      4'h2: pass = flg_c;
      4'h3: pass = !flg_c;
      4'h4: pass = flg_n;
      4'h5: pass = !flg_n;
      4'h6: pass = flg_v;
      4'h7: pass = !flg_v;
      4'h8: pass = flg_c && !flg_z;
      4'h9: pass = !flg_c || flg_z;
      4'hA: pass = (flg_n == flg_v);
      4'hB: pass = (flg_n != flg_v);
      4'hC: pass = !flg_z && (flg_n == flg_v);
      4'hD: pass = flg_z || (flg_n != flg_v);
      4'hE: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

  // cond=1111 is the unconditional space, which this core does not implement.
  always_comb begin
    cls = CLS_UNDEF;
    if (cond == 4'hF)
      cls = CLS_UNDEF;
    else if (in_instr[27:22] == 6'b000000 && in_instr[7:4] == 4'b1001)
      cls = CLS_MUL;
    else if (in_instr[27:26] == 2'b00)
      cls = CLS_DP;
    else if (in_instr[27:26] == 2'b01 && !(in_instr[25] && in_instr[4]))
      cls = CLS_LDST;
    else if (in_instr[27:25] == 3'b101)
      cls = CLS_BRANCH;
  end

  // A shift by 32 yields zero, so rot=0 leaves imm8 untouched.
  assign imm8_ext = {24'd0, in_instr[7:0]};
  assign rot_amt  = {in_instr[11:8], 1'b0};
  assign imm_rot  = (imm8_ext >> rot_amt) | (imm8_ext << (6'd32 - {1'b0, rot_amt}));

  always_comb begin
    dec           = '0;
    dec.cls       = cls;
    dec.cond_pass = pass;
    dec.pc        = in_pc;
    dec.br_target = in_pc + PC_W'(2) + in_instr[PC_W-1:0];
    dec.rn        = in_instr[19:16];
    dec.rd        = in_instr[15:12];
    dec.rs        = in_instr[11:8];
    dec.rm        = in_instr[3:0];
    case (cls)
      CLS_DP: begin
        dec.alu_op    = in_instr[24:21];
        dec.set_flags = in_instr[20];
        dec.imm_en    = in_instr[25];
        dec.imm_val   = imm_rot;
      end
      CLS_MUL: begin
        dec.set_flags = in_instr[20];
        dec.rd        = in_instr[19:16];
        dec.rn        = in_instr[15:12];
      end
      CLS_LDST: begin
        dec.imm_en  = !in_instr[25];
        dec.imm_val = {20'd0, in_instr[11:0]};
        dec.ls_ctl  = in_instr[24:20];
      end
      CLS_BRANCH: dec.br_link = in_instr[24];
      default: ;
    endcase
  end

  assign in_ready = !valid_q || out_ready;

  // Flush wins over capture; the held fields may go stale while invalid.
  always_comb begin
    valid_d = valid_q;
    rec_d   = rec_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (in_valid && in_ready) begin
      valid_d = 1'b1;
      rec_d   = dec;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q <= 1'b0;
      rec_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rec_q   <= rec_d;
    end
  end

  assign out_valid     = valid_q;
  assign out_class     = rec_q.cls;
  assign out_cond_pass = rec_q.cond_pass;
  assign out_alu_op    = rec_q.alu_op;
  assign out_set_flags = rec_q.set_flags;
  assign out_rn        = rec_q.rn;
  assign out_rd        = rec_q.rd;
  assign out_rs        = rec_q.rs;
  assign out_rm        = rec_q.rm;
  assign out_imm_en    = rec_q.imm_en;
  assign out_imm_val   = rec_q.imm_val;
  assign out_ls_ctl    = rec_q.ls_ctl;
  assign out_br_link   = rec_q.br_link;
  assign out_br_target = rec_q.br_target;
  assign out_pc        = rec_q.pc;

endmodule

// File: tb/tb_arm_decode_stage.sv
// Bench for arm_decode_stage: directed cases then randomized traffic against a transaction-level model.
module tb_arm_decode_stage;

  logic        CLK = 1'b0;
  logic        RST, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_instr;
  logic [7:0]  in_pc;
  logic [3:0]  flags_nzcv;
  logic [2:0]  out_class;
  logic        out_cond_pass, out_set_flags, out_imm_en, out_br_link;
  logic [3:0]  out_alu_op, out_rn, out_rd, out_rs, out_rm;
  logic [31:0] out_imm_val;
  logic [4:0]  out_ls_ctl;
  logic [7:0]  out_br_target, out_pc;

  arm_decode_stage #(.PC_W(8)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flags_nzcv(flags_nzcv), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_class(out_class), .out_cond_pass(out_cond_pass),
    .out_alu_op(out_alu_op), .out_set_flags(out_set_flags), .out_rn(out_rn), .out_rd(out_rd),
    .out_rs(out_rs), .out_rm(out_rm), .out_imm_en(out_imm_en), .out_imm_val(out_imm_val),
    .out_ls_ctl(out_ls_ctl), .out_br_link(out_br_link), .out_br_target(out_br_target),
    .out_pc(out_pc)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int      cls;
    bit      pass;
    int      alu, sf, rn, rd, rs, rm, ie, ls, bl, bt, pc;
    bit [31:0] imm;
    int      rmode;  // 0: registers unchecked, 1: rn/rd, 2: all four
  } exp_t;

  int   n_vec = 0;
  int   n_err = 0;
  bit   m_valid = 1'b0;
  bit   m_zero  = 1'b1;
  exp_t m_rec;
  exp_t zero_rec;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t ref_dec(input bit [31:0] ins, input int pc, input bit [3:0] f);
    exp_t    e;
    bit      n, z, c, v;
    bit [31:0] x;
    int      cnd;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    cnd = int'(ins[31:28]);
    e = '{cls: 7, pass: 0, imm: 0, rmode: 0, default: 0};
    case (cnd)
      0: e.pass = z;        1: e.pass = !z;
      2: e.pass = c;        3: e.pass = !c;
      4: e.pass = n;        5: e.pass = !n;
      6: e.pass = v;        7: e.pass = !v;
      8: e.pass = c && !z;  9: e.pass = !c || z;
      10: e.pass = (n == v); 11: e.pass = (n != v);
      12: e.pass = !z && (n == v);
      13: e.pass = z || (n != v);
      14: e.pass = 1;
      default: e.pass = 0;
    endcase
    if (cnd == 15) e.cls = 7;
    else if (ins[27:22] == 0 && ins[7:4] == 4'b1001) e.cls = 1;
    else if (ins[27:26] == 0) e.cls = 0;
    else if (ins[27:26] == 1 && !(ins[25] && ins[4])) e.cls = 2;
    else if (ins[27:25] == 3'b101) e.cls = 3;
    else e.cls = 7;
    e.pc = pc;
    e.bt = (pc + 2 + int'(ins[23:0])) % 256;
    if (e.cls == 0) begin
      x = {24'd0, ins[7:0]};
      for (int k = 0; k < 2 * int'(ins[11:8]); k++) x = {x[0], x[31:1]};
      e.alu = int'(ins[24:21]); e.sf = int'(ins[20]); e.ie = int'(ins[25]); e.imm = x;
      e.rn = int'(ins[19:16]); e.rd = int'(ins[15:12]); e.rs = int'(ins[11:8]); e.rm = int'(ins[3:0]);
      e.rmode = 2;
    end else if (e.cls == 1) begin
      e.sf = int'(ins[20]);
      e.rd = int'(ins[19:16]); e.rn = int'(ins[15:12]); e.rs = int'(ins[11:8]); e.rm = int'(ins[3:0]);
      e.rmode = 2;
    end else if (e.cls == 2) begin
      e.ie = ins[25] ? 0 : 1; e.imm = {20'd0, ins[11:0]}; e.ls = int'(ins[24:20]);
      e.rn = int'(ins[19:16]); e.rd = int'(ins[15:12]);
      e.rmode = 1;
    end else if (e.cls == 3) begin
      e.bl = int'(ins[24]);
    end
    return e;
  endfunction

  task automatic chk_rec(input exp_t e);
    chk_eq("class", 32'(out_class), 32'(e.cls));
    chk_eq("cond_pass", 32'(out_cond_pass), 32'(e.pass));
    chk_eq("alu_op", 32'(out_alu_op), 32'(e.alu));
    chk_eq("set_flags", 32'(out_set_flags), 32'(e.sf));
    chk_eq("imm_en", 32'(out_imm_en), 32'(e.ie));
    chk_eq("imm_val", out_imm_val, e.imm);
    chk_eq("ls_ctl", 32'(out_ls_ctl), 32'(e.ls));
    chk_eq("br_link", 32'(out_br_link), 32'(e.bl));
    chk_eq("br_target", 32'(out_br_target), 32'(e.bt));
    chk_eq("pc", 32'(out_pc), 32'(e.pc));
    if (e.rmode >= 1) begin
      chk_eq("rn", 32'(out_rn), 32'(e.rn));
      chk_eq("rd", 32'(out_rd), 32'(e.rd));
    end
    if (e.rmode == 2) begin
      chk_eq("rs", 32'(out_rs), 32'(e.rs));
      chk_eq("rm", 32'(out_rm), 32'(e.rm));
    end
  endtask

  // Called at a falling edge: drive, predict, cross one rising edge, then check.
  task automatic step(input bit rst, input bit iv, input bit [31:0] ins, input bit [7:0] pc,
                      input bit [3:0] f, input bit fl, input bit ordy);
    bit take;
    RST = rst; in_valid = iv; in_instr = ins; in_pc = pc; flags_nzcv = f;
    flush = fl; out_ready = ordy;
    #1;
    chk_eq("in_ready", 32'(in_ready), 32'(!m_valid || ordy));
    take = iv && (!m_valid || ordy);
    if (rst) begin
      m_valid = 0; m_zero = 1;
    end else if (fl) begin
      m_valid = 0;
    end else if (take) begin
      m_valid = 1; m_zero = 0; m_rec = ref_dec(ins, int'(pc), f);
    end else if (ordy) begin
      m_valid = 0;
    end
    @(posedge CLK);
    @(negedge CLK);
    chk_eq("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) chk_rec(m_rec);
    else if (m_zero) chk_rec(zero_rec);
  endtask

  task automatic gen_instr(output bit [31:0] ins);
    int kind;
    ins  = $urandom;
    kind = $urandom_range(0, 5);
    case (kind)
      1: ins[27:26] = 2'b00;
      2: begin ins[27:22] = 6'b000000; ins[7:4] = 4'b1001; end
      3: ins[27:26] = 2'b01;
      4: ins[27:25] = 3'b101;
      5: ins[31:28] = 4'hF;
      default: ;
    endcase
  endtask

  initial begin
    bit [31:0] ri;
    zero_rec = '{cls: 0, pass: 0, imm: 0, rmode: 2, default: 0};
    RST = 1; in_valid = 0; in_instr = 0; in_pc = 0; flags_nzcv = 0; flush = 0; out_ready = 1;
    @(negedge CLK);

    step(1, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    chk_eq("reset_in_ready", 32'(in_ready), 32'd1);

    step(0, 1, 32'hE3A01005, 8'h04, 4'h0, 0, 1);
    chk_eq("mov_alu", 32'(out_alu_op), 32'hD);
    chk_eq("mov_imm", out_imm_val, 32'd5);
    step(0, 1, 32'hE3A004FF, 8'h05, 4'h0, 0, 1);
    chk_eq("rot4_imm", out_imm_val, 32'hFF000000);
    step(0, 1, 32'hE0000291, 8'h06, 4'h0, 0, 1);
    chk_eq("mul_rs", 32'(out_rs), 32'd2);
    step(0, 1, 32'h0A000003, 8'h10, 4'b0000, 0, 1);
    chk_eq("beq_nz_pass", 32'(out_cond_pass), 32'd0);
    chk_eq("beq_target", 32'(out_br_target), 32'h15);
    step(0, 1, 32'h0A000003, 8'h10, 4'b0100, 0, 1);
    chk_eq("beq_z_pass", 32'(out_cond_pass), 32'd1);
    step(0, 1, 32'hEAFFFFFE, 8'h00, 4'h0, 0, 1);
    chk_eq("b_self_target", 32'(out_br_target), 32'h00);
    step(0, 1, 32'hF0000000, 8'h07, 4'hF, 0, 1);
    chk_eq("nv_class", 32'(out_class), 32'd7);
    step(0, 0, 0, 0, 0, 0, 1);

    step(0, 1, 32'hE3A01005, 8'h20, 4'h0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 32'hE5912004, 8'h21, 4'h0, 0, 0);
      chk_eq("hold_pc", 32'(out_pc), 32'h20);
    end
    step(0, 1, 32'hE5912004, 8'h21, 4'h0, 0, 1);
    chk_eq("second_pc", 32'(out_pc), 32'h21);
    step(0, 0, 0, 0, 0, 0, 1);

    step(0, 1, 32'hE3A01005, 8'h30, 4'h0, 0, 1);
    step(0, 1, 32'hE5912004, 8'h31, 4'h0, 1, 0);
    chk_eq("flush_valid", 32'(out_valid), 32'd0);

    for (int k = 0; k < 2000; k++) begin
      gen_instr(ri);
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, ri, 8'($urandom),
           4'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
